aes_dec_arbiter: RTL

Round-robin arbiter and sequencer that shares one AES-128 decryption core (`decryption_top`) between two requesters, A and B. It accepts a ciphertext/key pair over a valid/ready handshake, registers it and launches the core with a one-cycle `start`. It then waits for `done` and returns the plaintext, tagged with the requester id, over a valid/ready response channel. It sits between the system-side request sources and the single decryption datapath.

---
 rtl/aes_dec_arbiter_pkg.sv | 30 +++
 rtl/aes_dec_arbiter_if.sv | 49 ++++
 rtl/aes_dec_arbiter_rr_arb2.sv | 36 +++
 rtl/aes_dec_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/aes_dec_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// aes_dec_pkg : shared types for the AES-128 decryption-core arbiter.
//   AES_BLOCK_W  - width of ciphertext / key / plaintext blocks
//   arb_state_t  - sequencer states (IDLE, LAUNCH, BUSY, RESP)
//   req_id_t     - requester tag, 0 = A, 1 = B
//   arb_req_t    - latched operand bundle handed to the core
// -----------------------------------------------------------------------------
package aes_dec_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_A = 1'b0;
   localparam req_id_t REQ_B = 1'b1;

   typedef struct packed {
      logic [AES_BLOCK_W-1:0] ciphertext;
      logic [AES_BLOCK_W-1:0] key;
      req_id_t                id;
   } arb_req_t;

endpackage

// File: rtl/aes_dec_arbiter_if.sv
// -----------------------------------------------------------------------------
// aes_dec_arbiter_if : bundle of the arbiter's request, core and response
// signals.
//   slave  - arbiter side (accepts requests, drives the core, returns results)
//   master - environment side (requesters, decryption core, response consumer)
// -----------------------------------------------------------------------------
interface aes_dec_arbiter_if;
   import aes_dec_pkg::*;

   // requester A
   logic                   a_valid;
   logic                   a_ready;
   logic [AES_BLOCK_W-1:0] a_ciphertext;
   logic [AES_BLOCK_W-1:0] a_key;
   // requester B
   logic                   b_valid;
   logic                   b_ready;
   logic [AES_BLOCK_W-1:0] b_ciphertext;
   logic [AES_BLOCK_W-1:0] b_key;
   // decryption core
   logic                   core_start;
   logic [AES_BLOCK_W-1:0] core_ciphertext;
   logic [AES_BLOCK_W-1:0] core_key;
   logic [AES_BLOCK_W-1:0] core_plaintext;
   logic                   core_done;
   // response channel
   logic                   rsp_valid;
   logic                   rsp_ready;
   req_id_t                rsp_id;
   logic [AES_BLOCK_W-1:0] rsp_plaintext;
   logic                   rsp_err;

   modport slave (
      input  a_valid, a_ciphertext, a_key,
      input  b_valid, b_ciphertext, b_key,
      input  core_plaintext, core_done, rsp_ready,
      output a_ready, b_ready, core_start, core_ciphertext, core_key,
      output rsp_valid, rsp_id, rsp_plaintext, rsp_err
   );

   modport master (
      output a_valid, a_ciphertext, a_key,
      output b_valid, b_ciphertext, b_key,
      output core_plaintext, core_done, rsp_ready,
      input  a_ready, b_ready, core_start, core_ciphertext, core_key,
      input  rsp_valid, rsp_id, rsp_plaintext, rsp_err
   );

endinterface

// File: rtl/aes_dec_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2 : two-input round-robin grant.
//   clk, reset - clock, async active-high reset (pointer resets to favour A)
//   req[1:0]   - request vector, bit 0 = A, bit 1 = B
//   upd        - pointer update strobe (one cycle)
//   upd_id     - requester just served; the other one is favoured next
//   gnt[1:0]   - one-hot (or zero) grant, purely combinational from req
// -----------------------------------------------------------------------------
module rr_arb2
   import aes_dec_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   input  req_id_t    upd_id,
   output logic [1:0] gnt
);

   // index of the requester that wins a tie
   logic prio;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    prio <= REQ_A;
      else if (upd) prio <= ~upd_id;
   end

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt       = 2'b00;
         gnt[prio] = 1'b1;
      end
   end

endmodule

// File: rtl/aes_dec_arbiter.sv
// -----------------------------------------------------------------------------
// aes_dec_arbiter : shares one AES-128 decryption core between requesters
// A and B. Accepts a ciphertext/key pair, launches the core with a one-cycle
// start, waits for done and returns the tagged plaintext.
//   clk, reset - clock, async active-high reset
//   bus        - aes_dec_arbiter_if.slave: request A/B, core, response
//   TIMEOUT    - max BUSY cycles before an error response
// Optional feature macro: AES_ARB_TIMEOUT_EN (enables the BUSY watchdog;
// without it rsp_err is tied low and BUSY waits for done indefinitely).
// -----------------------------------------------------------------------------
module aes_dec_arbiter
   import aes_dec_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input logic        clk,
   input logic        reset,
   aes_dec_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_LAUNCH = LAUNCH;
   localparam logic [1:0] ST_BUSY   = BUSY;
   localparam logic [1:0] ST_RESP   = RESP;

   logic [1:0]             state;
   logic [1:0]             gnt;
   logic                   acc_a, acc_b;
   logic                   rsp_hs;
   logic                   tmo;
   arb_req_t               req_q;
   logic [AES_BLOCK_W-1:0] pt_q;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({bus.b_valid, bus.a_valid}),
      .upd    (rsp_hs),
      .upd_id (req_q.id),
      .gnt    (gnt)
   );

   // ready is only offered in IDLE, so the RESP handshake cycle never accepts
   assign acc_a  = (state == ST_IDLE) & gnt[0];
   assign acc_b  = (state == ST_IDLE) & gnt[1];
   assign rsp_hs = (state == ST_RESP) & bus.rsp_ready;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;
   logic             err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    cnt <= '0;
      else if (state == ST_LAUNCH)  cnt <= '0;
      else if (state == ST_BUSY)    cnt <= cnt + CNT_W'(1);
   end

   // fires in the BUSY cycle whose increment would reach TIMEOUT;
   // a done in that same cycle takes precedence in the FSM
   assign tmo = (state == ST_BUSY) && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else if (state == ST_BUSY) begin
         if (bus.core_done) err_q <= 1'b0;
         else if (tmo)      err_q <= 1'b1;
      end
   end

   assign bus.rsp_err = err_q;
`else
   localparam int timeout_unused = TIMEOUT;

   assign tmo         = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         req_q <= '0;
         pt_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (acc_b) begin
                  req_q <= '{ciphertext: bus.b_ciphertext, key: bus.b_key, id: REQ_B};
                  state <= ST_LAUNCH;
               end else if (acc_a) begin
                  req_q <= '{ciphertext: bus.a_ciphertext, key: bus.a_key, id: REQ_A};
                  state <= ST_LAUNCH;
               end
            end
            // done here belongs to nothing we launched; drop it
            ST_LAUNCH: state <= ST_BUSY;
            ST_BUSY: begin
               if (bus.core_done) begin
                  pt_q  <= bus.core_plaintext;
                  state <= ST_RESP;
               end else if (tmo) begin
                  pt_q  <= '0;
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.a_ready         = acc_a;
   assign bus.b_ready         = acc_b;
   assign bus.core_start      = (state == ST_LAUNCH);
   assign bus.core_ciphertext = req_q.ciphertext;
   assign bus.core_key        = req_q.key;
   assign bus.rsp_valid       = (state == ST_RESP);
   assign bus.rsp_id          = req_q.id;
   assign bus.rsp_plaintext   = pt_q;

endmodule
